// File: rtl/pp_strip_pkg.sv
// pp_strip_pkg: shared definitions for the preprocessor comment stripper.
//   - state_e   : scanner states (plain code, pending '/', line comment,
//                 block comment, block comment after '*', string, string escape)
//   - CH_*      : ASCII constants the scanner reacts to
//   - CNT_W_DEF : default width of the stripped-byte counter
package pp_strip_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_BSLASH = 8'h5C;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    NORM,
    SLASH,
    LINE,
    BLK,
    BLK_STAR,
    STR,
    STR_ESC
  } state_e;

endpackage

// File: rtl/pp_byte_reg.sv
// pp_byte_reg: one-entry output register with valid/ready stall handling.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   ld_i          : load a new byte (only asserted when can_ld_o is high)
//   ld_data_i     : byte to load
//   ld_last_i     : last-of-stream flag to load
//   can_ld_o      : register is empty or is being drained this cycle
//   out_valid_o   : output byte valid
//   out_ready_i   : downstream accepts the byte
//   out_data_o    : output byte
//   out_last_o    : output last flag
module pp_byte_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_i,
  input  logic [7:0] ld_data_i,
  input  logic       ld_last_i,
  output logic       can_ld_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_last_o
);

  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       out_last_q;

  assign can_ld_o    = !out_valid_q || out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

  // Data and last only change on a load, and loads only happen when the
  // register is empty or draining, so the byte holds steady while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else if (ld_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      out_valid_q <= 1'b1;
      out_data_q  <= ld_data_i;
      out_last_q  <= ld_last_i;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pp_comment_strip.sv
// pp_comment_strip: removes C/C++ comments from a byte stream feeding a
// macro-define capture. Line comments vanish up to (not including) the
// newline; block comments collapse to one space; string literals pass as-is.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake
//   in_data, in_last     : source byte and end-of-stream marker
//   out_valid/out_ready  : output handshake
//   out_data, out_last   : stripped byte and end-of-stream marker
//   strip_cnt            : saturating count of dropped bytes
//   unterm_err           : sticky, stream ended inside a block comment
module pp_comment_strip
  import pp_strip_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] strip_cnt,
  output logic             unterm_err
);

  state_e           state_q, state_d;
  logic             replay_v_q;
  logic [7:0]       replay_data_q;
  logic             replay_last_q;
  logic [CNT_W-1:0] strip_cnt_q, cnt_d;
  logic             unterm_err_q;

  logic       can_ld, proc_en;
  logic [7:0] cur_byte;
  logic       cur_last;
  logic       emit, emit_last, replay_ld, err_set;
  logic [7:0] emit_data;
  logic [1:0] cnt_inc;
  logic [CNT_W:0] cnt_sum;

  // A held replay byte takes priority over new input; it is consumed as soon
  // as the output register can take whatever it produces.
  assign in_ready = !rst && !replay_v_q && can_ld;
  assign proc_en  = replay_v_q ? can_ld : (in_valid && in_ready);
  assign cur_byte = replay_v_q ? replay_data_q : in_data;
  assign cur_last = replay_v_q ? replay_last_q : in_last;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    emit      = 1'b0;
    emit_data = cur_byte;
    emit_last = cur_last;
    replay_ld = 1'b0;
    cnt_inc   = 2'd0;
    err_set   = 1'b0;
    unique case (state_q)
      NORM: begin
        if (cur_byte == CH_SLASH) begin
          // A trailing '/' cannot start a comment; flush it as the last byte.
          if (cur_last) emit = 1'b1;
          else          state_d = SLASH;
        end else begin
          emit = 1'b1;
          if (cur_byte == CH_QUOTE && !cur_last) state_d = STR;
        end
      end
      SLASH: begin
        if (cur_byte == CH_SLASH) begin
          cnt_inc = 2'd2;
          state_d = NORM;
          if (cur_last) begin
            emit      = 1'b1;
            emit_data = CH_NL;
          end else begin
            state_d = LINE;
          end
        end else if (cur_byte == CH_STAR) begin
          cnt_inc = 2'd2;
          emit    = 1'b1;
          if (cur_last) begin
            emit_data = CH_NL;
            err_set   = 1'b1;
            state_d   = NORM;
          end else begin
            emit_data = CH_SPACE;
            state_d   = BLK;
          end
        end else begin
          // Not a comment: release the held '/' now and re-run this byte
          // (with its own last flag) through NORM next cycle.
          emit      = 1'b1;
          emit_data = CH_SLASH;
          emit_last = 1'b0;
          replay_ld = 1'b1;
          state_d   = NORM;
        end
      end
      LINE: begin
        if (cur_byte == CH_NL) begin
          emit    = 1'b1;
          state_d = NORM;
        end else begin
          cnt_inc = 2'd1;
          if (cur_last) begin
            emit      = 1'b1;
            emit_data = CH_NL;
            state_d   = NORM;
          end
        end
      end
      BLK, BLK_STAR: begin
        cnt_inc = 2'd1;
        if (cur_last) begin
          emit      = 1'b1;
          emit_data = CH_NL;
          state_d   = NORM;
          err_set   = !(state_q == BLK_STAR && cur_byte == CH_SLASH);
        end else if (cur_byte == CH_STAR) begin
          state_d = BLK_STAR;
        end else if (state_q == BLK_STAR && cur_byte == CH_SLASH) begin
          state_d = NORM;
        end else begin
          state_d = BLK;
        end
      end
      STR: begin
        emit = 1'b1;
        if (cur_last)                    state_d = NORM;
        else if (cur_byte == CH_BSLASH)  state_d = STR_ESC;
        else if (cur_byte == CH_QUOTE)   state_d = NORM;
      end
      STR_ESC: begin
        emit    = 1'b1;
        state_d = cur_last ? NORM : STR;
      end
      default: state_d = NORM;
    endcase
  end

  // Saturating add: one extra bit catches the overflow.
  assign cnt_sum = {1'b0, strip_cnt_q} + {{(CNT_W-1){1'b0}}, cnt_inc};
  assign cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= NORM;
      replay_v_q    <= 1'b0;
      replay_data_q <= 8'h00;
      replay_last_q <= 1'b0;
      strip_cnt_q   <= '0;
      unterm_err_q  <= 1'b0;
    end else if (proc_en) begin
      state_q     <= state_d;
      strip_cnt_q <= cnt_d;
      if (err_set) unterm_err_q <= 1'b1;
      if (replay_ld) begin
        replay_v_q    <= 1'b1;
        replay_data_q <= cur_byte;
        replay_last_q <= cur_last;
      end else if (replay_v_q) begin
        replay_v_q <= 1'b0;
      end
    end
  end

  assign strip_cnt  = strip_cnt_q;
  assign unterm_err = unterm_err_q;

  pp_byte_reg u_byte_reg (
    .clk         (clk),
    .rst         (rst),
    .ld_i        (proc_en && emit),
    .ld_data_i   (emit_data),
    .ld_last_i   (emit_last),
    .can_ld_o    (can_ld),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

endmodule

// File: tb/tb_pp_comment_strip.sv
// Testbench for pp_comment_strip: directed scenarios followed by random
// streams, all compared against a string-scanning reference model.
module tb_pp_comment_strip;

  typedef logic [7:0] bq_t[$];

  localparam logic [7:0] C_SL = 8'h2F, C_ST = 8'h2A, C_QU = 8'h22;
  localparam logic [7:0] C_BS = 8'h5C, C_NL = 8'h0A, C_SP = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready4;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid, out_valid4;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data, out_data4;
  logic        out_last, out_last4;
  logic [15:0] strip_cnt;
  logic [3:0]  strip_cnt4;
  logic        unterm_err, unterm_err4;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  bit exp_err = 0;

  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always #5 clk = ~clk;

  pp_comment_strip dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .strip_cnt(strip_cnt), .unterm_err(unterm_err)
  );

  pp_comment_strip #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4),
    .strip_cnt(strip_cnt4), .unterm_err(unterm_err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: scan the whole stream as text. Comments and strings are
  // recognised by looking ahead in the buffer; the end of the buffer decides
  // the trailing newline and the unterminated-comment flag.
  function automatic void ref_model(input bq_t src, output bq_t dst, output int cnt, output bit err);
    int n;
    int i;
    bit closed;
    logic [7:0] c;
    n = src.size();
    i = 0;
    dst = {};
    cnt = 0;
    err = 0;
    while (i < n) begin
      if (src[i] == C_QU) begin
        dst.push_back(src[i]);
        i++;
        while (i < n) begin
          c = src[i];
          dst.push_back(c);
          i++;
          if (c == C_BS) begin
            if (i < n) begin
              dst.push_back(src[i]);
              i++;
            end
          end else if (c == C_QU) begin
            break;
          end
        end
      end else if (src[i] == C_SL && i + 1 < n && src[i+1] == C_SL) begin
        cnt += 2;
        i += 2;
        while (i < n && src[i] != C_NL) begin
          cnt++;
          i++;
        end
        dst.push_back(C_NL);
        if (i < n) i++;
      end else if (src[i] == C_SL && i + 1 < n && src[i+1] == C_ST) begin
        cnt += 2;
        i += 2;
        if (i >= n) begin
          dst.push_back(C_NL);
          err = 1;
        end else begin
          dst.push_back(C_SP);
          closed = 0;
          while (i < n && !closed) begin
            cnt++;
            if (src[i] == C_ST && i + 1 < n && src[i+1] == C_SL) begin
              cnt++;
              i += 2;
              closed = 1;
            end else begin
              i++;
            end
          end
          if (!closed) begin
            dst.push_back(C_NL);
            err = 1;
          end else if (i >= n) begin
            dst.push_back(C_NL);
          end
        end
      end else begin
        dst.push_back(src[i]);
        i++;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_strip_cnt", {16'd0, strip_cnt}, 32'd0);
    check("rst_unterm_err", {31'd0, unterm_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_cnt = 0;
    exp_err = 0;
    prev_stall = 0;
  endtask

  // mode 0: always ready/valid; 1: random ready/valid; 2: stall the first '/'
  // presented on the output for three cycles.
  task automatic run_stream(input string tag, input bq_t src, input bit term,
                            input bq_t exp_out, input int mode);
    bq_t got;
    logic got_last[$];
    int idx = 0;
    int idle = 0;
    bit done = 0;
    int budget = 40 * src.size() + 100;
    int stall_left = 0;
    bit stalled_once = 0;
    bit chk_pending = 0;
    bit chk_now;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_stall_data"}, {24'd0, out_data}, {24'd0, prev_data});
        check({tag, "_stall_last"}, {31'd0, out_last}, {31'd0, prev_last});
      end
      chk_now = chk_pending;
      chk_pending = 0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 99) < 60);
        default: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
            if (stall_left == 0) chk_pending = 1;
          end else if (!stalled_once && out_valid && out_data == C_SL) begin
            stalled_once = 1;
            out_ready = 1'b0;
            stall_left = 2;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (idx < src.size()) begin
        in_valid = (mode == 1) ? ($urandom_range(0, 99) < 75) : 1'b1;
        in_data  = src[idx];
        in_last  = term && (idx == src.size() - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
      end
      #1;
      if (chk_now) check({tag, "_replay_in_ready"}, {31'd0, in_ready}, 32'd0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last && term) done = 1;
      end
      if (!term && idx == src.size()) begin
        idle++;
        if (idle > 4) done = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    check({tag, "_finished"}, {31'd0, done}, 32'd1);
    check({tag, "_len"}, got.size(), exp_out.size());
    for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_out[i]});
      check($sformatf("%s_last%0d", tag, i), {31'd0, got_last[i]},
            {31'd0, (term && i == exp_out.size() - 1)});
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_strip_cnt"}, {16'd0, strip_cnt}, (exp_cnt > 65535) ? 65535 : exp_cnt);
    check({tag, "_strip_cnt4"}, {28'd0, strip_cnt4}, (exp_cnt > 15) ? 15 : exp_cnt);
    check({tag, "_unterm_err"}, {31'd0, unterm_err}, {31'd0, exp_err});
  endtask

  initial begin
    bq_t s, e, m;
    int mc;
    bit me;
    logic [7:0] alph[8];

    alph = '{C_SL, C_ST, C_QU, C_BS, C_NL, 8'h61, C_SP, 8'h62};

    // Reset state
    do_reset();

    // Define line with trailing line comment; space before '//' survives
    s = str2q("define B 22 // c\n");
    s.push_front(8'h60);
    e = str2q("define B 22 \n");
    e.push_front(8'h60);
    run_stream("define", s, 1, e, 0);
    exp_cnt += 4;
    check_status("define");

    // Lone '/' with a stalled output and a pending replay byte
    run_stream("a_slash_b", str2q("a/b"), 1, str2q("a/b"), 2);
    check_status("a_slash_b");

    // Block comment collapses to a space
    run_stream("blk", str2q("x/*y*/z"), 1, str2q("x z"), 0);
    exp_cnt += 5;
    check_status("blk");

    // Comment markers inside a string pass unchanged
    s = {C_QU, C_SL, C_SL, C_QU};
    e = {C_QU, C_SL, C_SL, C_QU};
    run_stream("str", s, 1, e, 0);
    check_status("str");

    // Stream ends inside a block comment
    e = str2q("p \n");
    run_stream("unterm", str2q("p/*q"), 1, e, 0);
    exp_cnt += 3;
    exp_err = 1;
    check_status("unterm");

    // Reset while inside a line comment, then a fresh stream
    e = {};
    run_stream("line_part", str2q("//ab"), 0, e, 0);
    do_reset();
    run_stream("after_rst", str2q("k"), 1, str2q("k"), 0);
    check_status("after_rst");

    // 20-byte comment saturates the 4-bit counter
    run_stream("sat", str2q("/*0123456789abcdef*/"), 1, str2q(" \n"), 0);
    exp_cnt += 20;
    check_status("sat");

    // Random streams under random handshakes
    for (int t = 0; t < 40; t++) begin
      int len = $urandom_range(1, 20);
      s = {};
      for (int k = 0; k < len; k++) s.push_back(alph[$urandom_range(0, 7)]);
      ref_model(s, m, mc, me);
      run_stream($sformatf("rnd%0d", t), s, 1, m, 1);
      exp_cnt += mc;
      exp_err = exp_err | me;
      check_status($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pp_comment_strip.md
PP_COMMENT_STRIP -- requirements
Module: pp_comment_strip

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stripped-byte counter.
REQ-002 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have in_valid, input, 1, the input byte is valid.
REQ-005 SHALL have in_ready, output, 1, the block accepts the byte this cycle.
REQ-006 SHALL have in_data, input, 8, the source byte (ASCII).
REQ-007 SHALL have in_last, input, 1, marks the final byte of the stream.
REQ-008 SHALL have out_valid, output, 1, the output byte is valid.
REQ-009 SHALL have out_ready, input, 1, downstream (macro-define capture) accepts the byte.
REQ-010 SHALL have out_data, output, 8, the stripped byte.
REQ-011 SHALL have out_last, output, 1, marks the final output byte.
REQ-012 SHALL have strip_cnt, output, CNT_W, a saturating count of dropped bytes.
REQ-013 SHALL have unterm_err, output, 1, a sticky flag: the stream ended inside a block comment.

Function
REQ-014 The transfer rule SHALL be: a transfer occurs when valid and ready are both high on an edge. out_valid, out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-015 in_ready SHALL equal !replay_v && (!out_valid || out_ready).
REQ-016 In NORM, throughput SHALL be 1 byte/cycle and latency 1 cycle: a byte accepted at edge N is presented at N+1.
REQ-017 States SHALL be NORM, SLASH, LINE, BLK, BLK_STAR, STR, STR_ESC. Reset state SHALL be NORM.
REQ-018 NORM transitions:
- '/' -> SLASH, no output.
- '"' -> STR, emit.
- any other byte -> emit, stay in NORM.
REQ-019 SLASH transitions:
- '/' -> LINE, drop both bytes, strip_cnt += 2.
- '*' -> BLK, emit one space (0x20), strip_cnt += 2.
- any other byte -> emit '/', load the byte into the 1-entry replay register, go to NORM. The replay byte is processed as a NORM input next cycle.
REQ-020 LINE transitions:
- '\n' -> NORM, emit '\n'.
- any other byte, including '\' -> drop, strip_cnt += 1.
- Whitespace preceding '//' SHALL already have been emitted and is never removed.
REQ-021 BLK and BLK_STAR (every byte dropped, strip_cnt += 1):
- BLK: '*' -> BLK_STAR.
- BLK_STAR: '/' -> NORM; '*' -> stay; any other byte -> BLK.
REQ-022 STR and STR_ESC (every byte emitted):
- STR: '\' -> STR_ESC; '"' -> NORM.
- STR_ESC: any byte -> STR.
- '//' and '/*' inside a string SHALL pass unchanged.
REQ-023 End of stream, for a byte with in_last=1:
- If the byte is emitted, it SHALL carry out_last=1.
- If in_last arrives on '/' in NORM, the block SHALL emit '/' with out_last=1.
- If the byte is dropped (LINE/BLK/BLK_STAR, or SLASH->LINE/BLK), the block SHALL emit a single 0x0A with out_last=1.
- In every case the state returns to NORM.
REQ-024 If in_last is consumed in BLK or BLK_STAR without the closing '/', or on the '*' of SLASH->BLK, unterm_err SHALL set and hold until rst.
REQ-025 strip_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 A replay byte carrying in_last SHALL keep its last flag through replay.

Reset
REQ-027 rst SHALL clear, asynchronously:
- state = NORM;
- replay_v = 0;
- out_valid = out_last = 0, out_data = 0x00;
- strip_cnt = 0, unterm_err = 0.
REQ-028 in_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after deassertion.
REQ-029 Reset mid-stream SHALL discard any pending '/', replay byte and output byte; no partial comment state survives.

Structure
REQ-030 Package pp_strip_pkg SHALL hold:
- the state enum;
- the character constants (0x2F '/', 0x2A '*', 0x22 '"', 0x5C '\', 0x0A, 0x20);
- the CNT_W default.
REQ-031 The output register and stall logic SHALL be one sub-module, pp_byte_reg. The FSM and replay register stay in pp_comment_strip.

Verification
REQ-032 Stream "`define B 22 // c\n" -> output "`define B 22 \n" (space before // kept), strip_cnt=4.
REQ-033 Stream "a/b", out_ready held low 3 cycles while '/' is presented -> output "a/b", out_data stable during the stall, in_ready=0 while replay_v=1, strip_cnt=0.
REQ-034 Stream "x/*y*/z" -> output "x z", strip_cnt=5. Stream "\"//\"" -> identical output, strip_cnt=0.
REQ-035 Stream "p/*q" with in_last on 'q' -> output "p", 0x20, 0x0A (out_last=1), unterm_err=1, strip_cnt=3.
REQ-036 Assert rst while in LINE after "//ab", then stream "k" -> output "k", strip_cnt=0. Separately, with CNT_W=4, a 20-byte comment -> strip_cnt=15.
